// File: rtl/serial_pkg.sv
// Shared types and defaults for the bit-serial datapath blocks (serializer and serial adder side).
package serial_pkg;

  localparam int unsigned SERIAL_WIDTH = 8;

  typedef enum logic {
    IDLE,
    SHIFT
  } serial_state_e;

endpackage

// File: rtl/serial_operand_serializer.sv
// Captures an operand pair and emits it LSB first, one bit of A and B per cycle, with vld/last
// framing for the serial adder. Back-to-back pairs stream without a bubble.
module serial_operand_serializer
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = SERIAL_WIDTH,
  localparam int unsigned LEN_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [LEN_W-1:0] in_len,
  input  logic             hold,
  output logic             vld,
  output logic             a,
  output logic             b,
  output logic             last
);

  localparam logic [LEN_W-1:0] WidthLen = LEN_W'(WIDTH);

  serial_state_e    r_state, w_state_next;
  logic [WIDTH-1:0] r_a, r_b, w_a_next, w_b_next;
  logic [LEN_W-1:0] r_cnt, r_len, w_cnt_next, w_len_next;
  logic [LEN_W-1:0] w_eff_len;
  logic             w_vld, w_final, w_last, w_ready, w_accept;

  // Zero or oversize requests fall back to the full operand width.
  always_comb begin
    w_eff_len = in_len;
    if ((in_len == '0) || (in_len > WidthLen)) begin
      w_eff_len = WidthLen;
    end
  end

  // Outputs depend only on registered state, hold and rst.
  always_comb begin
    w_vld   = ~rst & (r_state == SHIFT) & ~hold;
    w_final = (r_cnt == (r_len - LEN_W'(1)));
    w_last  = w_vld & w_final;
    w_ready = ~rst & ((r_state == IDLE) | w_last);
  end

  assign w_accept = in_valid & w_ready;

  assign vld      = w_vld;
  assign last     = w_last;
  assign in_ready = w_ready;
  assign a        = w_vld & r_a[0];
  assign b        = w_vld & r_b[0];

  always_comb begin
    w_state_next = r_state;
    w_a_next     = r_a;
    w_b_next     = r_b;
    w_cnt_next   = r_cnt;
    w_len_next   = r_len;
    if (w_accept) begin
      // Covers both the IDLE start and the reload on the final bit of a pair.
      w_state_next = SHIFT;
      w_a_next     = in_a;
      w_b_next     = in_b;
      w_len_next   = w_eff_len;
      w_cnt_next   = '0;
    end else if (w_last) begin
      w_state_next = IDLE;
      w_cnt_next   = '0;
    end else if (w_vld) begin
      w_a_next   = {1'b0, r_a[WIDTH-1:1]};
      w_b_next   = {1'b0, r_b[WIDTH-1:1]};
      w_cnt_next = r_cnt + LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_next;
      r_a     <= w_a_next;
      r_b     <= w_b_next;
      r_cnt   <= w_cnt_next;
      r_len   <= w_len_next;
    end
  end

endmodule

// File: tb/tb_serial_operand_serializer.sv
// Directed bench: serializer feeding a serial adder model, sums reassembled LSB first.
module tb_serial_operand_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = 8'h00;
  logic [7:0] in_b = 8'h00;
  logic [3:0] in_len = 4'd0;
  logic       hold = 1'b0;
  logic       vld, a, b, last;

  int vectors = 0;
  int miscompares = 0;

  serial_operand_serializer #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a    (in_a),
    .in_b    (in_b),
    .in_len  (in_len),
    .hold    (hold),
    .vld     (vld),
    .a       (a),
    .b       (b),
    .last    (last)
  );

  always #5 clk = ~clk;

  // Serial adder model and stream recorder, sampled mid-cycle.
  int   vld_total = 0;
  int   last_total = 0;
  int   bit_i = 0;
  int   sum_acc = 0;
  int   run_len = 0;
  int   quiet_bad = 0;
  int   rst_bad = 0;
  logic carry = 1'b0;
  logic a_hist [0:255];
  int   sums_arr [0:15];
  int   last_at [0:15];
  int   run_at_last [0:15];
  logic sbit;

  assign sbit = a ^ b ^ carry;

  always_ff @(negedge clk) begin
    if (rst) begin
      bit_i   <= 0;
      carry   <= 1'b0;
      sum_acc <= 0;
      run_len <= 0;
      if (vld | in_ready | last | a | b) rst_bad <= rst_bad + 1;
    end else begin
      if (!vld && (a | b | last)) quiet_bad <= quiet_bad + 1;
      if (vld) begin
        a_hist[vld_total & 255] <= a;
        vld_total <= vld_total + 1;
        run_len   <= run_len + 1;
        if (last) begin
          sums_arr[last_total & 15]    <= sum_acc | (int'(sbit) << bit_i);
          last_at[last_total & 15]     <= vld_total + 1;
          run_at_last[last_total & 15] <= run_len + 1;
          last_total <= last_total + 1;
          bit_i      <= 0;
          carry      <= 1'b0;
          sum_acc    <= 0;
        end else begin
          sum_acc <= sum_acc | (int'(sbit) << bit_i);
          bit_i   <= bit_i + 1;
          carry   <= (a & b) | (a & carry) | (b & carry);
        end
      end else begin
        run_len <= 0;
      end
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int gather(input int base, input int n);
    int r = 0;
    for (int i = 0; i < n; i++) r = r | (int'(a_hist[(base + i) & 255]) << i);
    return r;
  endfunction

  task automatic send(input string tag, input logic [7:0] pa, input logic [7:0] pb,
                      input logic [3:0] pl);
    bit ok = 1'b0;
    in_a     = pa;
    in_b     = pb;
    in_len   = pl;
    in_valid = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    check({tag, "_accept"}, int'(ok), 1);
  endtask

  task automatic wait_lasts(input string tag, input int target);
    for (int i = 0; i < 100 && last_total < target; i++) @(posedge clk);
    #1;
    check({tag, "_done"}, last_total, target);
    repeat (2) @(posedge clk);
    #1;
  endtask

  int vb, lb;

  initial begin
    // Reset behaviour
    @(negedge clk);
    check("rst_vld", int'(vld), 0);
    check("rst_ready", int'(in_ready), 0);
    check("rst_last", int'(last), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", int'(in_ready), 1);
    check("post_rst_vld", int'(vld), 0);
    @(posedge clk);
    #1;

    // Full-width pair, in_len = 0
    vb = vld_total; lb = last_total;
    send("t1", 8'h35, 8'h0F, 4'd0);
    wait_lasts("t1", lb + 1);
    check("t1_vld_cycles", vld_total - vb, 8);
    check("t1_a_bits", gather(vb, 8), 32'h35);
    check("t1_last_pos", last_at[lb] - vb, 8);
    check("t1_sum", sums_arr[lb], 32'h44);

    // Back-to-back pairs
    vb = vld_total; lb = last_total;
    send("t2a", 8'hFF, 8'h01, 4'd0);
    send("t2b", 8'h02, 8'h03, 4'd0);
    wait_lasts("t2", lb + 2);
    check("t2_vld_cycles", vld_total - vb, 16);
    check("t2_run", run_at_last[lb + 1], 16);
    check("t2_sum0", sums_arr[lb], 32'h00);
    check("t2_sum1", sums_arr[lb + 1], 32'h05);
    check("t2_last0_pos", last_at[lb] - vb, 8);

    // Short length
    vb = vld_total; lb = last_total;
    send("t3", 8'hFF, 8'h00, 4'd3);
    wait_lasts("t3", lb + 1);
    check("t3_vld_cycles", vld_total - vb, 3);
    check("t3_last_pos", last_at[lb] - vb, 3);
    check("t3_a_bits", gather(vb, 3), 32'h7);
    check("t3_sum", sums_arr[lb], 32'h7);

    // Hold on bit 2 and on the last bit
    vb = vld_total; lb = last_total;
    send("t4", 8'h35, 8'h0F, 4'd0);
    for (int c = 0; c < 10; c++) begin
      hold = (c == 2) || (c == 8);
      @(negedge clk);
      if (c == 2 || c == 8) begin
        check($sformatf("t4_hold%0d_vld", c), int'(vld), 0);
        check($sformatf("t4_hold%0d_ready", c), int'(in_ready), 0);
      end
      if (c == 9) check("t4_final_last", int'(last), 1);
      @(posedge clk);
      #1;
    end
    hold = 1'b0;
    wait_lasts("t4", lb + 1);
    check("t4_vld_cycles", vld_total - vb, 8);
    check("t4_a_bits", gather(vb, 8), 32'h35);
    check("t4_sum", sums_arr[lb], 32'h44);

    // Reset mid-pair after bit 4
    vb = vld_total; lb = last_total;
    send("t5", 8'h35, 8'h0F, 4'd0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("t5_rst_vld", int'(vld), 0);
    check("t5_rst_ready", int'(in_ready), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t5_after_ready", int'(in_ready), 1);
    check("t5_after_vld", int'(vld), 0);
    check("t5_no_last", last_total, lb);
    check("t5_partial_bits", vld_total - vb, 5);
    @(posedge clk);
    #1;
    vb = vld_total; lb = last_total;
    send("t5b", 8'h5A, 8'h21, 4'd0);
    wait_lasts("t5b", lb + 1);
    check("t5b_vld_cycles", vld_total - vb, 8);
    check("t5b_a_bits", gather(vb, 8), 32'h5A);
    check("t5b_sum", sums_arr[lb], 32'h7B);

    // Oversize length clamps to WIDTH
    vb = vld_total; lb = last_total;
    send("t6", 8'h96, 8'h01, 4'd12);
    wait_lasts("t6", lb + 1);
    check("t6_vld_cycles", vld_total - vb, 8);
    check("t6_last_pos", last_at[lb] - vb, 8);
    check("t6_a_bits", gather(vb, 8), 32'h96);
    check("t6_sum", sums_arr[lb], 32'h97);

    check("quiet_outputs", quiet_bad, 0);
    check("reset_outputs", rst_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
